// File: rtl/fpu_normalize_round.sv
// fpu_normalize_round: two-stage normalise-and-round stage shared by the FPU
// add/mul/fma datapaths.
//
//   Stage 1: leading-zero count, normalising left shift, exponent adjust.
//   Stage 2: guard/sticky extraction, IEEE-754 rounding, overflow and
//            underflow handling. This stage drives the out_* registers.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid / in_ready        input handshake
//   in_sign                    result sign
//   in_exponent                signed biased exponent. in_mantissa[MSB] has weight 2^(exp-bias).
//   in_mantissa                unnormalised magnitude
//   in_sticky                  OR of bits already discarded upstream
//   in_round_mode              0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 act as RNE
//   out_valid / out_ready      output handshake
//   out_sign/exponent/mantissa packed result fields
//   out_inexact/overflow/underflow  exception flags
//
// Build option
//   FPU_NORM_SUBNORMAL_EN      When this is defined, tiny results are denormalised and rounded.
//                              When it is undefined, tiny results flush to zero.
module fpu_normalize_round #(
  parameter int IN_WIDTH  = 47,
  parameter int MAN_WIDTH = 23,
  parameter int EXP_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_WIDTH+1:0]   in_exponent,
  input  logic [IN_WIDTH-1:0]    in_mantissa,
  input  logic                   in_sticky,
  input  logic [2:0]             in_round_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sign,
  output logic [EXP_WIDTH-1:0]   out_exponent,
  output logic [MAN_WIDTH-1:0]   out_mantissa,
  output logic                   out_inexact,
  output logic                   out_overflow,
  output logic                   out_underflow
);

  localparam int STAGES = 2;
  localparam int LZW    = $clog2(IN_WIDTH + 1);
  // one extra bit so exponent arithmetic can see its own wrap
  localparam int EXW    = EXP_WIDTH + 3;

  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  typedef struct packed {
    logic                 sign;
    logic [EXP_WIDTH+1:0] exp;
    logic [IN_WIDTH-1:0]  norm;
    logic                 sticky;
    logic                 zero;
    logic [2:0]           rm;
  } s1_t;

  logic [STAGES:1] vld_pipe;
  logic            s2_advance;
  s1_t             s1_d, s1_q;

  assign s2_advance = !vld_pipe[2] || out_ready;
  assign in_ready   = !vld_pipe[1] || s2_advance;
  assign out_valid  = vld_pipe[2];

  // ---------------- stage 1: LZC + normalise ----------------
  logic [LZW-1:0] lz;
  logic [EXW-1:0] exp1_w;

  always_comb begin
    // scanning upward means the last hit is the most significant one
    lz = LZW'(IN_WIDTH);
    for (int i = 0; i < IN_WIDTH; i++)
      if (in_mantissa[i]) lz = LZW'(IN_WIDTH - 1 - i);
  end

  always_comb begin
    exp1_w      = {in_exponent[EXP_WIDTH+1], in_exponent} - EXW'(lz);
    s1_d        = '0;
    s1_d.sign   = in_sign;
    s1_d.norm   = in_mantissa << lz;
    s1_d.sticky = in_sticky;
    s1_d.zero   = (in_mantissa == '0) && !in_sticky;
    s1_d.rm     = in_round_mode;
    // The value can only leave the signed range toward the negative side, so clamp it there.
    // That case is hopelessly tiny in any event.
    if (exp1_w[EXW-1] != exp1_w[EXW-2])
      s1_d.exp = {1'b1, {(EXP_WIDTH+1){1'b0}}};
    else
      s1_d.exp = exp1_w[EXW-2:0];
  end

  // ---------------- stage 2: round + exceptions ----------------
  logic [MAN_WIDTH:0]   keep;
  logic                 guard, sticky, inexact;
  logic [IN_WIDTH-1:0]  rest;
  logic [EXP_WIDTH+1:0] e1;
  logic [EXW-1:0]       e1x, exp_r, exp_away;
  logic                 tiny, inc, carry, trunc, ovf;
  logic [MAN_WIDTH-1:0] frac;

  logic                 n_sign, n_inx, n_ovf, n_unf;
  logic [EXP_WIDTH-1:0] n_exp;
  logic [MAN_WIDTH-1:0] n_man;

`ifdef FPU_NORM_SUBNORMAL_EN
  localparam int DW = 2 * (MAN_WIDTH + 2);
  localparam int SW = $clog2(MAN_WIDTH + 3);
  logic [EXW-1:0] dist;
  logic [SW-1:0]  shamt;
  logic [DW-1:0]  dwide;
  logic           hid_r;
`endif

  // This returns true when the exponent is at or above the all-ones value.
  // It is read as a signed number.
  function automatic logic at_max(input logic [EXW-1:0] x);
    return !x[EXW-1] && ((x[EXW-2:EXP_WIDTH] != '0) || (&x[EXP_WIDTH-1:0]));
  endfunction

  always_comb begin
    e1     = s1_q.exp;
    e1x    = {e1[EXP_WIDTH+1], e1};
    keep   = s1_q.norm[IN_WIDTH-1 -: MAN_WIDTH+1];
    guard  = s1_q.norm[IN_WIDTH-MAN_WIDTH-2];
    rest   = s1_q.norm << (MAN_WIDTH + 2);
    sticky = (|rest) | s1_q.sticky;
    tiny   = e1[EXP_WIDTH+1] || (e1 == '0);

`ifdef FPU_NORM_SUBNORMAL_EN
    dist  = EXW'(1) - e1x;
    shamt = (dist > EXW'(MAN_WIDTH + 2)) ? SW'(MAN_WIDTH + 2) : dist[SW-1:0];
    dwide = '0;
    if (tiny) begin
      dwide  = {keep, guard, {(MAN_WIDTH+2){1'b0}}} >> shamt;
      keep   = dwide[DW-1 -: MAN_WIDTH+1];
      guard  = dwide[MAN_WIDTH+2];
      sticky = sticky | (|dwide[MAN_WIDTH+1:0]);
    end
`endif

    inexact = guard | sticky;

    // trunc=1: this mode never rounds the magnitude up, so an overflow
    // saturates to max finite instead of going to infinity.
    inc   = guard & (sticky | keep[0]);
    trunc = 1'b0;
    case (s1_q.rm)
      RM_RTZ: begin inc = 1'b0;                     trunc = 1'b1;        end
      RM_RDN: begin inc = s1_q.sign & inexact;      trunc = !s1_q.sign;  end
      RM_RUP: begin inc = !s1_q.sign & inexact;     trunc = s1_q.sign;   end
      RM_RMM: begin inc = guard;                    trunc = 1'b0;        end
      default: ;
    endcase

    carry    = (&keep) & inc;
    frac     = keep[MAN_WIDTH-1:0] + MAN_WIDTH'(inc);  // wraps to 0 on carry
    exp_r    = e1x + EXW'(carry);
    // exponent if the exact magnitude were rounded away from zero. This is used to
    // flag an overflow for a result whose exact value exceeds max finite
    // while the mode truncates it back.
    exp_away = e1x + EXW'((&keep) & inexact);
    ovf      = !tiny && (at_max(exp_r) || (trunc && at_max(exp_away)));

    n_sign = s1_q.sign;
    n_exp  = exp_r[EXP_WIDTH-1:0];
    n_man  = frac;
    n_inx  = inexact;
    n_ovf  = 1'b0;
    n_unf  = 1'b0;

`ifdef FPU_NORM_SUBNORMAL_EN
    hid_r = keep[MAN_WIDTH] | ((&keep[MAN_WIDTH-1:0]) & inc);
    if (tiny) begin
      n_exp = EXP_WIDTH'(hid_r);
      n_unf = inexact;
    end
`else
    if (tiny) begin
      n_exp = '0;
      n_man = '0;
      n_inx = 1'b1;
      n_unf = 1'b1;
    end
`endif

    if (ovf) begin
      n_ovf = 1'b1;
      n_inx = 1'b1;
      if (trunc) begin
        n_exp = {{(EXP_WIDTH-1){1'b1}}, 1'b0};
        n_man = '1;
      end else begin
        n_exp = '1;
        n_man = '0;
      end
    end

    if (s1_q.zero) begin
      n_exp = '0;
      n_man = '0;
      n_inx = 1'b0;
      n_ovf = 1'b0;
      n_unf = 1'b0;
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe      <= '0;
      s1_q          <= '0;
      out_sign      <= 1'b0;
      out_exponent  <= '0;
      out_mantissa  <= '0;
      out_inexact   <= 1'b0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      if (in_ready)             vld_pipe[1] <= in_valid;
      if (in_valid && in_ready) s1_q        <= s1_d;
      if (s2_advance)           vld_pipe[2] <= vld_pipe[1];
      if (s2_advance && vld_pipe[1]) begin
        out_sign      <= n_sign;
        out_exponent  <= n_exp;
        out_mantissa  <= n_man;
        out_inexact   <= n_inx;
        out_overflow  <= n_ovf;
        out_underflow <= n_unf;
      end
    end
  end

endmodule

// File: tb/tb_fpu_normalize_round.sv
module tb_fpu_normalize_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign, in_sticky;
  logic [9:0]  in_exponent;
  logic [46:0] in_mantissa;
  logic [2:0]  in_round_mode;
  logic        out_valid, out_ready, out_sign;
  logic [7:0]  out_exponent;
  logic [22:0] out_mantissa;
  logic        out_inexact, out_overflow, out_underflow;

  fpu_normalize_round #(.IN_WIDTH(47), .MAN_WIDTH(23), .EXP_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exponent(in_exponent), .in_mantissa(in_mantissa),
    .in_sticky(in_sticky), .in_round_mode(in_round_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exponent(out_exponent), .out_mantissa(out_mantissa),
    .out_inexact(out_inexact), .out_overflow(out_overflow),
    .out_underflow(out_underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic        i, o, u;
  } res_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_acc = 0;
  int   beat  = 0;

  localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;
  localparam logic [46:0] ONE  = 47'h1;
  localparam logic [46:0] TOP  = ONE << 46;
  localparam logic [46:0] GRD  = ONE << 22;
  localparam logic [46:0] L0   = ONE << 23;
  localparam logic [46:0] ALLG = (47'hFFFFFF << 23) | GRD;

  function automatic res_t mk(input logic s, input int e, input logic [22:0] m,
                              input logic i, input logic o, input logic u);
    res_t r;
    r.s = s; r.e = 8'(e); r.m = m; r.i = i; r.o = o; r.u = u;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Holds a beat on the input until it is accepted. The expected result is queued at acceptance.
  task automatic send(input logic s, input int e, input logic [46:0] m, input logic st,
                      input logic [2:0] rm, input res_t x);
    int  t  = 0;
    bit  ok = 0;
    in_valid = 1'b1; in_sign = s; in_exponent = 10'(e);
    in_mantissa = m; in_sticky = st; in_round_mode = rm;
    while (!ok && t < 50) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        exp_q.push_back(x);
        n_acc++;
      end
      @(posedge clk); #1;
      t++;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout in_ready stayed 0 for %0d cycles", t);
    end
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor: this compares every beat that the DUT hands off.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      res_t got, want;
      got = {out_sign, out_exponent, out_mantissa, out_inexact, out_overflow, out_underflow};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL beat%0d unexpected output e=%0d m=%h", beat, out_exponent, out_mantissa);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_bad++;
          $display("FAIL beat%0d got s=%0d e=%0d m=%h ixo=%0d%0d%0d want s=%0d e=%0d m=%h ixo=%0d%0d%0d",
                   beat, got.s, got.e, got.m, got.i, got.o, got.u,
                   want.s, want.e, want.m, want.i, want.o, want.u);
        end
      end
      beat++;
    end
  end

  initial begin
    int t;
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_sticky = 1'b0;
    in_exponent = '0; in_mantissa = '0; in_round_mode = RNE; out_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_exp",   32'(out_exponent), 0);
    chk("rst_out_man",   32'(out_mantissa), 0);
    chk("rst_out_flags", 32'({out_sign, out_inexact, out_overflow, out_underflow}), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // latency: this beat is accepted at edge A. It is invisible after A and visible after A+1.
    send(0, 127, TOP, 0, RNE, mk(0, 127, 23'h0, 0, 0, 0));
    @(negedge clk); chk("lat_not_yet", 32'(out_valid), 0);
    @(negedge clk); chk("lat_two",     32'(out_valid), 1);
    @(posedge clk); #1;

    // stream of directed vectors sent back to back
    send(0, 130, ONE << 40, 0, RNE, mk(0, 124, 23'h0, 0, 0, 0));
    send(0, 127, ALLG, 0, RNE, mk(0, 128, 23'h0, 1, 0, 0));
    send(0, 127, ALLG, 0, RTZ, mk(0, 127, 23'h7FFFFF, 1, 0, 0));
    send(0, 254, ALLG, 0, RNE, mk(0, 255, 23'h0, 1, 1, 0));
    send(0, 254, ALLG, 0, RTZ, mk(0, 254, 23'h7FFFFF, 1, 1, 0));
    send(0, 254, ALLG, 0, RDN, mk(0, 254, 23'h7FFFFF, 1, 1, 0));
    send(0, 254, ALLG, 0, RUP, mk(0, 255, 23'h0, 1, 1, 0));
    send(1, 254, ALLG, 0, RDN, mk(1, 255, 23'h0, 1, 1, 0));
    send(0, 300, TOP, 0, RNE, mk(0, 255, 23'h0, 1, 1, 0));
`ifdef FPU_NORM_SUBNORMAL_EN
    send(0, 1, ONE << 45, 0, RNE, mk(0, 0, 23'h400000, 0, 0, 0));
`else
    send(0, 1, ONE << 45, 0, RNE, mk(0, 0, 23'h0, 1, 0, 1));
`endif
    send(1, 100, '0, 0, RNE, mk(1, 0, 23'h0, 0, 0, 0));                  // zero
    send(0, 127, TOP | GRD, 0, RNE, mk(0, 127, 23'h0, 1, 0, 0));         // tie, even
    send(0, 127, TOP | L0 | GRD, 0, RNE, mk(0, 127, 23'h2, 1, 0, 0));    // tie, odd
    send(0, 127, TOP | L0 | GRD, 0, 3'd7, mk(0, 127, 23'h2, 1, 0, 0));   // mode 7 = RNE
    send(0, 127, TOP | ONE, 0, RUP, mk(0, 127, 23'h1, 1, 0, 0));
    send(0, 127, TOP | ONE, 0, RDN, mk(0, 127, 23'h0, 1, 0, 0));
    send(1, 127, TOP | ONE, 0, RDN, mk(1, 127, 23'h1, 1, 0, 0));
    send(0, 127, TOP | GRD, 0, RMM, mk(0, 127, 23'h1, 1, 0, 0));
    send(0, 127, TOP, 1, RUP, mk(0, 127, 23'h1, 1, 0, 0));               // upstream sticky
    send(0, 200, ONE, 0, RNE, mk(0, 154, 23'h0, 0, 0, 0));               // lz=46

    t = 0;
    while (exp_q.size() != 0 && t < 100) begin @(posedge clk); t++; end
    chk("drain_stream", 32'(exp_q.size()), 0);
    @(posedge clk); #1;

    // backpressure: 4 beats are offered while the output stalls for 5 cycles
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int k = 0; k < 4; k++)
          send(0, 10 + k, TOP, 0, RNE, mk(0, 10 + k, 23'h0, 0, 0, 0));
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bp_accepts", 32'(n_acc), 2);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_out_held", 32'(out_exponent), 10);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin @(posedge clk); t++; end
    chk("drain_bp", 32'(exp_q.size()), 0);
    chk("bp_all_accepted", 32'(n_acc), 4);
    @(posedge clk); #1;

    // reset mid-stream discards the in-flight beats
    send(0, 50, TOP, 0, RNE, mk(0, 50, 23'h0, 0, 0, 0));
    send(0, 51, TOP, 0, RNE, mk(0, 51, 23'h0, 0, 0, 0));
    chk("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", 32'(out_valid), 0);
    chk("post_rst_ready", 32'(in_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpu_normalize_round.md
Name: fpu_normalize_round

Overview:
- Pipelined, parametrised normalise-and-round stage shared by FPU add/mul/fma datapaths.
- Takes a raw wide mantissa product or sum with a biased exponent.
- Performs leading-zero count, normalising left shift, sticky collection and IEEE-754 rounding, with valid/ready handshaking.
- Generalises the fixed-width 27/47-bit LZC/sticky helpers to arbitrary widths and formats, and adds rounding modes, overflow/underflow handling and a 2-stage pipeline.

Parameters:
- IN_WIDTH, 47, width of incoming unnormalised mantissa.
- MAN_WIDTH, 23, stored fraction width of output format (hidden bit excluded); must satisfy IN_WIDTH >= MAN_WIDTH+2.
- EXP_WIDTH, 8, biased exponent width of output format.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_sign  in  1  result sign
- in_exponent  in  EXP_WIDTH+2  signed biased exponent; weight of in_mantissa[IN_WIDTH-1] is 2^(in_exponent-bias)
- in_mantissa  in  IN_WIDTH  unnormalised magnitude
- in_sticky  in  1  OR of bits already discarded upstream
- in_round_mode  in  3  0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 treated as RNE
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_sign  out  1
- out_exponent  out  EXP_WIDTH  biased exponent
- out_mantissa  out  MAN_WIDTH  fraction
- out_inexact  out  1  guard|round|sticky nonzero
- out_overflow  out  1
- out_underflow  out  1  tiny and inexact

Behaviour:
- Reset (async, rst=1): both stage valid flags 0; all out_* data registers 0; in_ready=1 on first cycle after reset release.
- Stage 1 (registered):
  - lz = count of leading zeros of in_mantissa, 0..IN_WIDTH; lz=IN_WIDTH when mantissa==0.
  - norm = in_mantissa << lz.
  - exp1 = in_exponent - lz (signed, EXP_WIDTH+2 bits, no wrap).
  - Zero flag set when in_mantissa==0 && !in_sticky.
- Stage 2 (registered, drives outputs):
  - keep = norm[IN_WIDTH-1 -: MAN_WIDTH+1]; guard = next bit; sticky = OR(remaining bits) | in_sticky.
  - Round-up decision:
    - RNE: guard & (sticky | keep[0]).
    - RTZ: never.
    - RDN: sign & (guard|sticky).
    - RUP: !sign & (guard|sticky).
    - RMM: guard.
  - Carry out of keep+1 → mantissa = 1.000…, exponent+1.
  - Exponent >= 2^EXP_WIDTH-1 after rounding → out_overflow=1, out_inexact=1:
    - RNE/RMM, or round direction matching sign → exp all-ones, mantissa 0 (infinity).
    - Otherwise → max finite (exp all-ones-1, mantissa all-ones).
  - Exponent <= 0 (without optional feature) → flush: exp 0, mantissa 0, out_underflow=1, out_inexact=1.
  - Zero flag → exp 0, mantissa 0, sign preserved, all flags 0.
- Handshake:
  - Each stage advances when its successor is empty or draining.
  - in_ready = !s1_valid || s2_advance; s2_advance = !out_valid || out_ready.
  - Latency is exactly 2 cycles with out_ready held high; throughput is 1 beat/cycle.
  - out_* data is held stable while out_valid && !out_ready.
  - Simultaneous accept and drain in the same cycle incurs no bubble.
  - No beat is dropped or duplicated.
- Reset mid-stream discards all in-flight beats.

Optional Feature:
- FPU_NORM_SUBNORMAL_EN
  - Defined: when exp1 <= 0, stage 2 right-shifts keep/guard by (1-exp1), saturating at MAN_WIDTH+2. Bits shifted out OR into sticky. Rounding then proceeds as normal with output exp 0. A round carry into the hidden bit produces exp 1. out_underflow = result tiny && inexact.
  - Undefined: flush-to-zero as above; the shifter is not synthesised.

Test Plan:
- in_mantissa=1<<46, in_exponent=127, RNE, out_ready=1 → 2 cycles later exp=127, mant=0x000000, inexact=0.
- in_mantissa=1<<40, in_exponent=130 → lz=6; exp=124, mant=0.
- top 24 bits 0xFFFFFF, guard=1, rest 0, sticky=0, exp=127:
  - RNE → exp=128, mant=0, inexact=1.
  - RTZ → exp=127, mant=0x7FFFFF.
- Same mantissa, exp=254:
  - RNE → exp=255, mant=0, overflow=1.
  - RTZ → exp=254, mant=0x7FFFFF, overflow=1.
- in_mantissa=1<<45, exp=1:
  - Macro undefined → exp=0, mant=0, underflow=1.
  - Macro defined → exp=0, mant=0x400000, underflow=0.
- Backpressure: out_ready=0 for 5 cycles while 4 beats are offered → in_ready falls after 2 accepts; on release, beats exit in order with no loss. Assert rst mid-stream → out_valid=0 immediately.
